note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Step sequencer that plays the synth voice: it drives the voice's trigger and oscillator period (trig, osc_count) from a 16-entry pattern table.
- Runs in the fast system clock domain. It times trigger pulses in multiples of one envelope-clock period, so the slow two-flop trigger synchroniser in the voice always captures every note-on and every note-off.
- The table and the tempo are written by the host through a simple write port.

Parameters:
- STEPS, 16, pattern table depth (power of two).
- TICK_DIV, 262144, clk cycles per tick; this equals one envelope-clock period (512*512). Overridden to small values in simulation.
- OSC_W, 12, oscillator period width.

Ports:
- clk  in  1  system clock, 20.48 MHz.
- rstn  in  1  asynchronous reset, active-low.
- run  in  1  level; 1 = play the pattern, 0 = stop.
- tempo  in  8  ticks per step, minus 1; sampled at each step load.
- last_step  in  log2(STEPS)  index of the final step before wrapping to 0.
- wr_en  in  1  table write strobe, one cycle.
- wr_addr  in  log2(STEPS)  table entry to write.
- wr_data  in  OSC_W+5  field layout: [OSC_W+4] rest, [OSC_W+3:OSC_W] gate ticks, [OSC_W-1:0] osc period.
- trig  out  1  note gate to the voice.
- osc_count  out  OSC_W  oscillator period to the voice.
- step_idx  out  log2(STEPS)  index of the step currently playing.
- step_strobe  out  1  one-cycle pulse on each step load.
- playing  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rstn=0) forces:
  - state IDLE;
  - trig=0, osc_count=0, step_idx=0, step_strobe=0, playing=0;
  - all table entries to 0;
  - prescaler to 0.
- Prescaler:
  - Free-running 0..TICK_DIV-1 from reset.
  - tick is a one-cycle internal pulse when the count equals TICK_DIV-1.
  - All state changes below happen only in a tick cycle, except table writes and the immediate-stop path.
- Effective values, computed when a step is loaded:
  - tempo_eff = max(tempo,1).
  - gate_eff = min(max(gate,1), tempo_eff).
  - The step lasts tempo_eff+1 ticks.
  - trig is high for gate_eff ticks, so trig is low for at least 1 tick before the next step. This guarantees a retrigger edge.
- States: IDLE, GATE, REL.
- IDLE:
  - On a tick with run=1, load step 0.
  - Load means: step_idx<=0; osc_count<=entry.osc unless rest=1, in which case osc_count keeps its previous value; trig<=~rest; tick_cnt<=0; step_strobe=1 in that same cycle; state<=GATE.
- GATE, on each tick:
  - tick_cnt++.
  - When the new tick_cnt equals gate_eff: trig<=0 and state<=REL.
- REL, on each tick:
  - tick_cnt++.
  - When tick_cnt was already tempo_eff at this tick: load the next step.
  - Next step is step_idx+1, or 0 if step_idx>=last_step. A last_step lowered below step_idx therefore wraps at the next load.
  - Load goes to GATE with the same rules as from IDLE.
- Rest steps:
  - trig stays 0 for the whole step.
  - Timing is identical to a normal step (GATE then REL).
- Stop:
  - run=0 in any state forces trig=0 combinationally-registered on the next clk edge, not waiting for a tick.
  - The state then returns to IDLE at the next tick.
  - step_idx and osc_count hold their values until the next start, which always begins at step 0.
- Table writes:
  - Accepted in any cycle; the entry is written on the clk edge.
  - A write to the currently playing step does not alter the outputs. It takes effect the next time that step is loaded.
  - A write coinciding with the load of the same entry: the load uses the old data.
- Simultaneous events:
  - run falling in a load tick: the load is suppressed and the state goes to IDLE with trig=0.
  - tempo changes take effect at the next load only.
- osc_count and trig change only on clk edges and are glitch-free registers.

Test Plan:
- Reset and stop: hold rstn=0 mid-GATE with trig=1 -> all outputs 0 asynchronously; after release with run=0 -> playing=0 and trig=0 for 20 ticks.
- Basic play (TICK_DIV=4): entries 0..2 = {rest 0, gate 2, osc 100/200/300}, last_step=2, tempo=3, run=1 ->
  - trig high 8 clk and low 8 clk per step;
  - step_strobe every 16 clk;
  - osc_count cycles 100, 200, 300, 100;
  - step_idx wraps 2->0.
- Clamping: gate=15 with tempo=1 -> trig high 1 tick and low 1 tick, period 2 ticks. tempo=0 -> same result. gate=0 -> trig high 1 tick.
- Rest step: entry 1 rest=1, osc=999 -> trig stays 0 through step 1 and osc_count holds 100; step timing unchanged.
- Write during play: write entry 0 osc=555 while step 0 is playing -> osc_count stays 100 until the next wrap, then becomes 555. A write in the same cycle as the step-0 load -> the old value is used.
- Stop mid-gate: run=0 while trig=1 -> trig=0 one clk later; playing=0 at the next tick; run=1 restarts at step_idx=0.

Source files
------------

// File: rtl/note_sequencer.sv
// Step sequencer driving the synth voice's trig/osc_count from a host-written pattern table.
// Trigger pulses are timed in whole ticks (one envelope-clock period) so the voice's slow synchroniser sees every edge.
module note_sequencer #(
  parameter int STEPS    = 16,
  parameter int TICK_DIV = 262144,
  parameter int OSC_W    = 12,
  localparam int AW      = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic [7:0]       tempo,
  input  logic [AW-1:0]    last_step,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [OSC_W+4:0] wr_data,
  output logic             trig,
  output logic [OSC_W-1:0] osc_count,
  output logic [AW-1:0]    step_idx,
  output logic             step_strobe,
  output logic             playing
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = OSC_W + 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_s;
  logic [DW-1:0]    tbl_q [STEPS];
  logic [7:0]       tick_cnt_q, tick_cnt_d;
  logic [7:0]       tempo_eff_q, tempo_eff_d;
  logic [7:0]       gate_eff_q, gate_eff_d;
  logic [AW-1:0]    step_idx_q, step_idx_d;
  logic [OSC_W-1:0] osc_q, osc_d;
  logic             trig_q, trig_d;
  logic             strobe_q, strobe_d;
  logic             playing_q, playing_d;

  logic             load_s;
  logic [AW-1:0]    next_idx_s;
  logic [DW-1:0]    entry_s;
  logic             rest_s;
  logic [3:0]       gate_s;
  logic [OSC_W-1:0] osc_s;
  logic [7:0]       tempo_eff_s;
  logic [7:0]       gate_raw_s;
  logic [7:0]       gate_eff_s;
  logic [7:0]       tick_cnt_inc_s;

  // Free-running tick prescaler
  always_comb begin
    tick_s = (presc_q == PW'(TICK_DIV - 1));
    if (tick_s) begin
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Prescaler register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= {PW{1'b0}};
    end else begin
      presc_q <= presc_d;
    end
  end

  // Pattern table; a load in the same cycle as a write reads the old entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STEPS; i++) begin
        tbl_q[i] <= {DW{1'b0}};
      end
    end else if (wr_en) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  // Next step selection and effective gate/tempo for the step being loaded
  always_comb begin
    if (state_q == ST_IDLE) begin
      next_idx_s = {AW{1'b0}};
    end else if (step_idx_q >= last_step) begin
      next_idx_s = {AW{1'b0}};
    end else begin
      next_idx_s = step_idx_q + {{(AW-1){1'b0}}, 1'b1};
    end
    entry_s     = tbl_q[next_idx_s];
    rest_s      = entry_s[DW-1];
    gate_s      = entry_s[OSC_W+3:OSC_W];
    osc_s       = entry_s[OSC_W-1:0];
    tempo_eff_s = (tempo == 8'd0) ? 8'd1 : tempo;
    gate_raw_s  = (gate_s == 4'd0) ? 8'd1 : {4'd0, gate_s};
    if (gate_raw_s > tempo_eff_s) begin
      gate_eff_s = tempo_eff_s;
    end else begin
      gate_eff_s = gate_raw_s;
    end
  end

  // Sequencer next-state and output logic
  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    tempo_eff_d    = tempo_eff_q;
    gate_eff_d     = gate_eff_q;
    step_idx_d     = step_idx_q;
    osc_d          = osc_q;
    trig_d         = trig_q;
    strobe_d       = 1'b0;
    load_s         = 1'b0;
    tick_cnt_inc_s = tick_cnt_q + 8'd1;

    // Stop drops trig immediately; the FSM itself only moves on a tick
    if (!run) begin
      trig_d = 1'b0;
      if (tick_s) begin
        state_d = ST_IDLE;
      end else begin
        state_d = state_q;
      end
    end else if (tick_s) begin
      case (state_q)
        ST_IDLE: begin
          load_s = 1'b1;
        end
        ST_GATE: begin
          tick_cnt_d = tick_cnt_inc_s;
          if (tick_cnt_inc_s == gate_eff_q) begin
            trig_d  = 1'b0;
            state_d = ST_REL;
          end else begin
            state_d = ST_GATE;
          end
        end
        ST_REL: begin
          if (tick_cnt_q == tempo_eff_q) begin
            load_s = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_inc_s;
          end
        end
        default: begin
          trig_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (load_s) begin
      step_idx_d  = next_idx_s;
      osc_d       = rest_s ? osc_q : osc_s;
      trig_d      = ~rest_s;
      tick_cnt_d  = 8'd0;
      tempo_eff_d = tempo_eff_s;
      gate_eff_d  = gate_eff_s;
      strobe_d    = 1'b1;
      state_d     = ST_GATE;
    end else begin
      strobe_d = 1'b0;
    end

    playing_d = (state_d != ST_IDLE);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= 8'd0;
      tempo_eff_q <= 8'd1;
      gate_eff_q  <= 8'd1;
      step_idx_q  <= {AW{1'b0}};
      osc_q       <= {OSC_W{1'b0}};
      trig_q      <= 1'b0;
      strobe_q    <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      tempo_eff_q <= tempo_eff_d;
      gate_eff_q  <= gate_eff_d;
      step_idx_q  <= step_idx_d;
      osc_q       <= osc_d;
      trig_q      <= trig_d;
      strobe_q    <= strobe_d;
      playing_q   <= playing_d;
    end
  end

  assign trig        = trig_q;
  assign osc_count   = osc_q;
  assign step_idx    = step_idx_q;
  assign step_strobe = strobe_q;
  assign playing     = playing_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a 4-clock tick; expectations are hand-derived step waveforms.
module tb_note_sequencer;

  logic        clk;
  logic        rstn;
  logic        run;
  logic [7:0]  tempo;
  logic [3:0]  last_step;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [16:0] wr_data;
  logic        trig;
  logic [11:0] osc_count;
  logic [3:0]  step_idx;
  logic        step_strobe;
  logic        playing;

  int tests;
  int fails;

  note_sequencer #(.STEPS(16), .TICK_DIV(4), .OSC_W(12)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .run        (run),
    .tempo      (tempo),
    .last_step  (last_step),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .trig       (trig),
    .osc_count  (osc_count),
    .step_idx   (step_idx),
    .step_strobe(step_strobe),
    .playing    (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [16:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_strobe(input int maxc);
    int n;
    n = 0;
    @(negedge clk);
    while (step_strobe !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_wait", 32'(step_strobe), 32'd1);
  endtask

  // Entered at the strobe sample of a step; leaves at the strobe sample of the next one.
  task automatic play_step(input logic [3:0] e_idx, input logic [11:0] e_osc, input int hi,
                           input int len, input int wr_at, input logic [3:0] wa, input logic [16:0] wd);
    int bad;
    bad = 0;
    chk($sformatf("idx_s%0d", e_idx), 32'(step_idx), 32'(e_idx));
    chk($sformatf("osc_s%0d", e_idx), 32'(osc_count), 32'(e_osc));
    for (int k = 0; k < len; k++) begin
      if (step_strobe !== (k == 0)) bad++;
      if (trig !== (k < hi)) bad++;
      if (osc_count !== e_osc) bad++;
      if (step_idx !== e_idx) bad++;
      if (playing !== 1'b1) bad++;
      if (k == wr_at) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk($sformatf("wave_s%0d_bad_cycles", e_idx), 32'(bad), 32'd0);
  endtask

  initial begin
    int bad;
    tests = 0; fails = 0;
    rstn = 1'b1; run = 1'b0; tempo = 8'd3; last_step = 4'd2;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 17'd0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_osc", 32'(osc_count), 32'd0);
    chk("rst_idx", 32'(step_idx), 32'd0);
    chk("rst_strobe", 32'(step_strobe), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    @(negedge clk) rstn = 1'b1;

    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (playing !== 1'b0 || trig !== 1'b0) bad++;
    end
    chk("idle_after_reset", 32'(bad), 32'd0);

    // Basic play: gate 2, tempo 3 -> 8 clk high, 8 clk low, 16 clk per step
    wr(4'd0, {1'b0, 4'd2, 12'd100});
    wr(4'd1, {1'b0, 4'd2, 12'd200});
    wr(4'd2, {1'b0, 4'd2, 12'd300});
    run = 1'b1;
    wait_strobe(40);
    play_step(4'd0, 12'd100, 8, 16, -1, 4'd0, 17'd0);
    play_step(4'd1, 12'd200, 8, 16, -1, 4'd0, 17'd0);
    play_step(4'd2, 12'd300, 8, 16, -1, 4'd0, 17'd0);
    // Write to the playing step 0; must not disturb it
    play_step(4'd0, 12'd100, 8, 16, 3, 4'd0, {1'b0, 4'd2, 12'd555});
    play_step(4'd1, 12'd200, 8, 16, 5, 4'd1, {1'b1, 4'd2, 12'd999});
    play_step(4'd2, 12'd300, 8, 16, -1, 4'd0, 17'd0);
    play_step(4'd0, 12'd555, 8, 16, -1, 4'd0, 17'd0);
    // Rest step: trig stays low, osc holds
    play_step(4'd1, 12'd555, 0, 16, -1, 4'd0, 17'd0);
    // Write landing on the step-0 load edge: old data used
    play_step(4'd2, 12'd300, 8, 16, 15, 4'd0, {1'b0, 4'd2, 12'd777});
    play_step(4'd0, 12'd555, 8, 16, -1, 4'd0, 17'd0);
    play_step(4'd1, 12'd555, 0, 16, -1, 4'd0, 17'd0);
    play_step(4'd2, 12'd300, 8, 16, -1, 4'd0, 17'd0);
    play_step(4'd0, 12'd777, 8, 16, -1, 4'd0, 17'd0);
    play_step(4'd1, 12'd777, 0, 16, -1, 4'd0, 17'd0);

    // Stop mid-gate during step 2
    chk("stop_pre_trig", 32'(trig), 32'd1);
    @(negedge clk) run = 1'b0;
    @(negedge clk);
    chk("stop_trig_1clk", 32'(trig), 32'd0);
    chk("stop_playing_pre_tick", 32'(playing), 32'd1);
    @(negedge clk);
    chk("stop_playing_pre_tick2", 32'(playing), 32'd1);
    @(negedge clk);
    chk("stop_playing_tick", 32'(playing), 32'd0);
    chk("stop_idx_hold", 32'(step_idx), 32'd2);
    chk("stop_osc_hold", 32'(osc_count), 32'd300);

    // Clamping: gate 15 / gate 0 with tempo 1, then tempo 0, then tempo 3
    wr(4'd0, {1'b0, 4'd15, 12'h123});
    wr(4'd1, {1'b0, 4'd0, 12'h456});
    last_step = 4'd1;
    tempo = 8'd1;
    run = 1'b1;
    wait_strobe(40);
    play_step(4'd0, 12'h123, 4, 8, -1, 4'd0, 17'd0);
    play_step(4'd1, 12'h456, 4, 8, -1, 4'd0, 17'd0);
    tempo = 8'd0;
    play_step(4'd0, 12'h123, 4, 8, -1, 4'd0, 17'd0);
    play_step(4'd1, 12'h456, 4, 8, -1, 4'd0, 17'd0);
    tempo = 8'd3;
    play_step(4'd0, 12'h123, 4, 8, -1, 4'd0, 17'd0);
    play_step(4'd1, 12'h456, 4, 16, -1, 4'd0, 17'd0);
    play_step(4'd0, 12'h123, 12, 16, -1, 4'd0, 17'd0);

    // Async reset mid-gate of step 1
    @(negedge clk);
    chk("pre_reset_trig", 32'(trig), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_trig", 32'(trig), 32'd0);
    chk("arst_osc", 32'(osc_count), 32'd0);
    chk("arst_idx", 32'(step_idx), 32'd0);
    chk("arst_strobe", 32'(step_strobe), 32'd0);
    chk("arst_playing", 32'(playing), 32'd0);
    run = 1'b0;
    @(negedge clk) rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (playing !== 1'b0 || trig !== 1'b0) bad++;
    end
    chk("idle_after_arst", 32'(bad), 32'd0);

    // Table cleared by reset: entry 0 plays gate 1, osc 0
    run = 1'b1;
    wait_strobe(40);
    play_step(4'd0, 12'd0, 4, 16, -1, 4'd0, 17'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
